fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the 16-bit pipelined CPU: owns the program counter, drives the instruction-memory address, and holds the IF/ID pipeline register feeding decode. It consumes the hazard unit's stallF, stallD, flushD and InstBranch outputs plus the branch target computed in decode. A three-state control FSM sequences reset release and a HALT opcode with external resume.

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset
- IMEM_AW, 8, instruction-memory address width (word-addressed)
- HALT_OP, 4'hF, opcode (instr[15:12]) that halts fetch

- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- stallF  in  1  hold PC
- stallD  in  1  hold IF/ID register
- flushD  in  1  load bubble into IF/ID
- InstBranch  in  1  taken branch; redirect PC
- branchTargetD  in  16  branch target from decode
- resume  in  1  single-cycle pulse; leave HALT
- imem_addr  out  IMEM_AW  = pc[IMEM_AW-1:0], combinational from PC register
- imem_data  in  16  instruction at imem_addr, asynchronous-read ROM
- instrD  out  16  IF/ID instruction
- pcD  out  16  IF/ID PC of instrD
- pcPlus1D  out  16  IF/ID pcD+1
- validD  out  1  IF/ID holds a real instruction
- halted  out  1  FSM in HALT
- fetch_count  out  16  instructions loaded into IF/ID with validD=1

## Operation
- Reset values: pc=RESET_PC, instrD=16'h0000 (NOP), pcD=0, pcPlus1D=0, validD=0, halted=0, fetch_count=0, state=BOOT.
- FSM: BOOT -> RUN unconditionally after one clock. RUN -> HALT when imem_data[15:12]==HALT_OP and IF/ID loads this cycle (no InstBranch, no stallF, no stallD, no flushD). HALT -> RUN on resume or InstBranch.
- PC next-value priority (RUN): InstBranch -> branchTargetD; else stallF -> hold; else pc+1. pc+1 wraps 16'hFFFF -> 16'h0000.
- PC in BOOT: hold. PC in HALT: InstBranch -> branchTargetD; else resume -> pc+1; else hold. The halt instruction's PC is held while halted.
- IF/ID priority: flushD or state==BOOT -> bubble (instrD=NOP, validD=0, pcD/pcPlus1D=0). Else stallD -> hold all fields. Else state==HALT -> bubble. Else load {imem_data, pc, pc+1, validD=1}.
- The halt instruction itself enters IF/ID as valid. Every later IF/ID load is a bubble until exit.
- InstBranch always arrives with stallF=stallD=flushD=1. The FSM ignores stallF when InstBranch=1. flushD beats stallD, so IF/ID takes a bubble.
- InstBranch in the same cycle as a HALT_OP fetch: no halt; the branch wins.
- fetch_count increments on every IF/ID load with validD=1 and wraps at 16'hFFFF.
- halted = (state==HALT), registered.

## Timing
- IF/ID latency: one clock. imem_addr reflects the current pc with no register.
- Branch: InstBranch=1 in cycle n -> pc=branchTargetD and a bubble in IF/ID at n+1. The target instruction is in IF/ID at n+2.
- Stall: stallF=stallD=1 in cycle n -> pc and IF/ID unchanged at n+1.
- Halt: HALT_OP fetched at n -> halt in IF/ID and halted=1 at n+1. Bubbles from n+2.
- Resume pulse at m -> pc=halt_pc+1 and halted=0 at m+1. The next instruction is in IF/ID at m+2.
- rst_n assertion mid-operation asynchronously returns every output to its reset value within the same cycle. The first valid fetch is in IF/ID two clocks after rst_n deassertion.

## Structure
- Shared package cpu_pkg: NOP_INSTR=16'h0000, HALT_OP, fetch FSM state encoding (BOOT, RUN, HALT; 2 bits), DATA_W=16.
- Sub-module if_id_reg: the IF/ID register with flush>stall>load priority and async active-low reset. fetch_stage instantiates it and keeps the PC, FSM and fetch_count.

## Test plan
- Reset release, ROM with 0x1000..0x1004 at addresses 0..4 -> BOOT cycle with validD=0. Then instrD=0x1000, pcD=0 two clocks after deassert, followed by 0x1001, 0x1002; fetch_count=3.
- stallF=stallD=1 for 2 cycles at pc=3 -> imem_addr stays 3 and instrD/pcD hold. Fetch resumes with pcD=3.
- InstBranch=1 with branchTargetD=0x0040 (stall/flush also 1) -> next cycle pc=0x40 and validD=0. The following cycle pcD=0x40.
- HALT_OP 0xF000 at address 5 -> instrD=0xF000 valid, halted=1, bubbles after, pc held at 5. resume pulse -> halted=0 and pcD=6 two clocks later.
- HALT_OP fetched in the same cycle as InstBranch to 0x0010 -> halted stays 0 and pc=0x10.
- pc=16'hFFFF sequential fetch -> pc wraps to 0. rst_n pulsed low mid-run -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit pipelined CPU front end.
package cpu_pkg;

   localparam int DATA_W = 16;

   localparam logic [DATA_W-1:0] NOP_INSTR = 16'h0000;
   localparam logic [3:0]        HALT_OP   = 4'hF;

   // Fetch control FSM encoding
   typedef enum logic [1:0] {
      FS_BOOT = 2'd0,
      FS_RUN  = 2'd1,
      FS_HALT = 2'd2
   } fetch_state_e;

   // Contents of the IF/ID pipeline register
   typedef struct packed {
      logic [DATA_W-1:0] instr;
      logic [DATA_W-1:0] pc;
      logic [DATA_W-1:0] pc_plus1;
      logic              valid;
   } if_id_t;

   localparam if_id_t IF_ID_BUBBLE = '{
      instr:    NOP_INSTR,
      pc:       16'h0000,
      pc_plus1: 16'h0000,
      valid:    1'b0
   };

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats stall, stall beats bubble, bubble beats load.
module if_id_reg
   import cpu_pkg::*;
(
   input  logic   clk,
   input  logic   rst_n,
   input  logic   flush_i,
   input  logic   stall_i,
   input  logic   bubble_i,
   input  if_id_t load_i,
   output if_id_t q_o
);

   if_id_t ifid_q;
   if_id_t ifid_d;

   // Select the next register contents by priority
   always_comb begin
      ifid_d = ifid_q;
      if (flush_i) begin
         ifid_d = IF_ID_BUBBLE;
      end else if (stall_i) begin
         ifid_d = ifid_q;
      end else if (bubble_i) begin
         ifid_d = IF_ID_BUBBLE;
      end else begin
         ifid_d = load_i;
      end
   end

   // Register with asynchronous return to a bubble
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ifid_q <= IF_ID_BUBBLE;
      end else begin
         ifid_q <= ifid_d;
      end
   end

   assign q_o = ifid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, imem address, boot/run/halt control and IF/ID register.
module fetch_stage
   import cpu_pkg::*;
#(
   parameter logic [DATA_W-1:0] RESET_PC = 16'h0000,
   parameter int                IMEM_AW  = 8,
   parameter logic [3:0]        HALT_OP  = cpu_pkg::HALT_OP
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               stallF,
   input  logic               stallD,
   input  logic               flushD,
   input  logic               InstBranch,
   input  logic [DATA_W-1:0]  branchTargetD,
   input  logic               resume,
   output logic [IMEM_AW-1:0] imem_addr,
   input  logic [DATA_W-1:0]  imem_data,
   output logic [DATA_W-1:0]  instrD,
   output logic [DATA_W-1:0]  pcD,
   output logic [DATA_W-1:0]  pcPlus1D,
   output logic               validD,
   output logic               halted,
   output logic [DATA_W-1:0]  fetch_count
);

   fetch_state_e      state_q;
   logic              halted_q;
   logic [DATA_W-1:0] pc_q;
   logic [DATA_W-1:0] pc_d;
   logic [DATA_W-1:0] pc_plus1;
   logic [DATA_W-1:0] count_q;
   logic              in_boot;
   logic              in_halt;
   logic              if_load;
   logic              halt_take;
   if_id_t            ifid_load;
   if_id_t            ifid;

   assign pc_plus1  = pc_q + 16'd1;
   assign imem_addr = pc_q[IMEM_AW-1:0];
   assign in_boot   = (state_q == FS_BOOT);
   assign in_halt   = (state_q == FS_HALT);

   // A real instruction enters IF/ID only when nothing blocks the load
   assign if_load   = !flushD && !stallD && !InstBranch && !in_boot && !in_halt;
   assign halt_take = if_load && (imem_data[15:12] == HALT_OP);

   // Next PC: a branch always wins; a halting fetch keeps its own PC
   always_comb begin
      pc_d = pc_q;
      case (state_q)
         FS_RUN: begin
            if (InstBranch) begin
               pc_d = branchTargetD;
            end else if (!stallF && !halt_take) begin
               pc_d = pc_plus1;
            end
         end
         FS_HALT: begin
            if (InstBranch) begin
               pc_d = branchTargetD;
            end else if (resume) begin
               pc_d = pc_plus1;
            end
         end
         default: pc_d = pc_q;
      endcase
   end

   // Program counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   // Fetch control FSM with registered halted flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= FS_BOOT;
         halted_q <= 1'b0;
      end else begin
         case (state_q)
            FS_BOOT: begin
               state_q  <= FS_RUN;
               halted_q <= 1'b0;
            end
            FS_RUN: begin
               if (halt_take) begin
                  state_q  <= FS_HALT;
                  halted_q <= 1'b1;
               end
            end
            FS_HALT: begin
               if (resume || InstBranch) begin
                  state_q  <= FS_RUN;
                  halted_q <= 1'b0;
               end
            end
            default: begin
               state_q  <= FS_BOOT;
               halted_q <= 1'b0;
            end
         endcase
      end
   end

   // Count valid instructions handed to decode
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= 16'h0000;
      end else if (if_load) begin
         count_q <= count_q + 16'd1;
      end
   end

   assign ifid_load = '{instr: imem_data, pc: pc_q, pc_plus1: pc_plus1, valid: 1'b1};

   if_id_reg u_if_id (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush_i  (flushD | in_boot),
      .stall_i  (stallD),
      .bubble_i (in_halt),
      .load_i   (ifid_load),
      .q_o      (ifid)
   );

   assign instrD      = ifid.instr;
   assign pcD         = ifid.pc;
   assign pcPlus1D    = ifid.pc_plus1;
   assign validD      = ifid.valid;
   assign halted      = halted_q;
   assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios, then randomized traffic.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stallF = 1'b0;
   logic        stallD = 1'b0;
   logic        flushD = 1'b0;
   logic        InstBranch = 1'b0;
   logic [15:0] branchTargetD = 16'h0000;
   logic        resume = 1'b0;
   logic [7:0]  imem_addr;
   logic [15:0] imem_data;
   logic [15:0] instrD;
   logic [15:0] pcD;
   logic [15:0] pcPlus1D;
   logic        validD;
   logic        halted;
   logic [15:0] fetch_count;

   logic [15:0] rom [256];
   assign imem_data = rom[imem_addr];

   always #5 clk = ~clk;

   fetch_stage dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .stallF        (stallF),
      .stallD        (stallD),
      .flushD        (flushD),
      .InstBranch    (InstBranch),
      .branchTargetD (branchTargetD),
      .resume        (resume),
      .imem_addr     (imem_addr),
      .imem_data     (imem_data),
      .instrD        (instrD),
      .pcD           (pcD),
      .pcPlus1D      (pcPlus1D),
      .validD        (validD),
      .halted        (halted),
      .fetch_count   (fetch_count)
   );

   int tests = 0;
   int failed = 0;

   // Reference model: architectural view of the fetch stage
   logic [15:0] m_pc, m_instr, m_pcD, m_pcp1, m_cnt;
   bit          m_boot, m_halt, m_valid;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc = 16'h0000; m_instr = 16'h0000; m_pcD = 16'h0000; m_pcp1 = 16'h0000;
      m_cnt = 16'h0000; m_valid = 1'b0; m_boot = 1'b1; m_halt = 1'b0;
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".addr"},   32'(imem_addr),   32'(m_pc[7:0]));
      chk({tag, ".instr"},  32'(instrD),      32'(m_instr));
      chk({tag, ".pcD"},    32'(pcD),         32'(m_pcD));
      chk({tag, ".pcp1"},   32'(pcPlus1D),    32'(m_pcp1));
      chk({tag, ".valid"},  32'(validD),      32'(m_valid));
      chk({tag, ".halted"}, 32'(halted),      32'(m_halt));
      chk({tag, ".count"},  32'(fetch_count), 32'(m_cnt));
   endtask

   // Advance one clock: predict from current inputs, then compare after the edge
   task automatic cycle(input string tag);
      logic [15:0] ins, n_pc, n_instr, n_pcD, n_pcp1, n_cnt;
      bit          load, is_halt, n_halt, n_valid;
      ins     = rom[m_pc[7:0]];
      load    = !flushD && !stallD && !InstBranch && !m_boot && !m_halt;
      is_halt = load && (ins[15:12] == 4'hF);
      if (m_boot)          n_pc = m_pc;
      else if (InstBranch) n_pc = branchTargetD;
      else if (m_halt)     n_pc = resume ? m_pc + 16'd1 : m_pc;
      else if (stallF || is_halt) n_pc = m_pc;
      else                 n_pc = m_pc + 16'd1;
      if (m_boot)      n_halt = 1'b0;
      else if (m_halt) n_halt = !(resume || InstBranch);
      else             n_halt = is_halt;
      n_instr = m_instr; n_pcD = m_pcD; n_pcp1 = m_pcp1; n_valid = m_valid;
      if (flushD || m_boot || (!stallD && m_halt)) begin
         n_instr = 16'h0000; n_pcD = 16'h0000; n_pcp1 = 16'h0000; n_valid = 1'b0;
      end else if (!stallD) begin
         n_instr = ins; n_pcD = m_pc; n_pcp1 = m_pc + 16'd1; n_valid = 1'b1;
      end
      n_cnt = load ? m_cnt + 16'd1 : m_cnt;
      @(posedge clk);
      #1;
      m_pc = n_pc; m_halt = n_halt; m_boot = 1'b0;
      m_instr = n_instr; m_pcD = n_pcD; m_pcp1 = n_pcp1; m_valid = n_valid; m_cnt = n_cnt;
      check_all(tag);
   endtask

   task automatic set_branch(input logic [15:0] tgt);
      InstBranch = 1'b1; stallF = 1'b1; stallD = 1'b1; flushD = 1'b1; branchTargetD = tgt;
   endtask

   task automatic clear_ctl();
      InstBranch = 1'b0; stallF = 1'b0; stallD = 1'b0; flushD = 1'b0; resume = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) rom[i] = 16'h1000 + 16'(i);
      rom[5]     = 16'hF000;
      rom[8'h41] = 16'hF000;

      // Reset and boot
      model_reset();
      #1;
      check_all("reset");
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      cycle("boot");
      chk("boot_valid", 32'(validD), 32'd0);
      cycle("f0");
      chk("f0_instr", 32'(instrD), 32'h1000);
      chk("f0_pcD", 32'(pcD), 32'h0);
      cycle("f1");
      cycle("f2");
      chk("f2_instr", 32'(instrD), 32'h1002);
      chk("f2_count", 32'(fetch_count), 32'd3);

      // Two-cycle stall at pc=3
      stallF = 1'b1; stallD = 1'b1;
      cycle("stall1");
      cycle("stall2");
      chk("stall_addr", 32'(imem_addr), 32'd3);
      chk("stall_pcD", 32'(pcD), 32'd2);
      clear_ctl();
      cycle("unstall");
      chk("unstall_pcD", 32'(pcD), 32'd3);
      cycle("f4");

      // Halt at address 5, then resume
      cycle("halt");
      chk("halt_instr", 32'(instrD), 32'hF000);
      chk("halt_valid", 32'(validD), 32'd1);
      chk("halt_flag", 32'(halted), 32'd1);
      cycle("halt_b1");
      cycle("halt_b2");
      chk("halt_bubble", 32'(validD), 32'd0);
      chk("halt_pc", 32'(imem_addr), 32'd5);
      resume = 1'b1;
      cycle("resume");
      resume = 1'b0;
      chk("resume_flag", 32'(halted), 32'd0);
      chk("resume_pc", 32'(imem_addr), 32'd6);
      cycle("after_resume");
      chk("after_resume_pcD", 32'(pcD), 32'd6);

      // Taken branch
      set_branch(16'h0040);
      cycle("branch");
      chk("branch_pc", 32'(imem_addr), 32'h40);
      chk("branch_bubble", 32'(validD), 32'd0);
      clear_ctl();
      cycle("branch_tgt");
      chk("branch_tgt_pcD", 32'(pcD), 32'h40);

      // Branch while a halt opcode is being fetched (pc=0x41)
      set_branch(16'h0010);
      cycle("halt_br");
      chk("halt_br_flag", 32'(halted), 32'd0);
      chk("halt_br_pc", 32'(imem_addr), 32'h10);
      clear_ctl();
      cycle("halt_br_tgt");

      // PC wrap
      set_branch(16'hFFFF);
      cycle("to_ffff");
      clear_ctl();
      cycle("wrap");
      chk("wrap_pcD", 32'(pcD), 32'hFFFF);
      chk("wrap_pcp1", 32'(pcPlus1D), 32'h0);
      chk("wrap_addr", 32'(imem_addr), 32'h0);
      cycle("post_wrap");

      // Asynchronous reset mid-cycle
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all("async_rst");
      chk("async_rst_count", 32'(fetch_count), 32'd0);

      // Randomized traffic against the model
      for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int c = 0; c < 800; c++) begin
         if ($urandom_range(0, 15) == 0) begin
            set_branch(16'($urandom));
            resume = 1'b0;
         end else begin
            InstBranch = 1'b0;
            stallF = ($urandom_range(0, 7) == 0);
            stallD = ($urandom_range(0, 7) == 0);
            flushD = ($urandom_range(0, 9) == 0);
            resume = !resume && ($urandom_range(0, 3) == 0);
            branchTargetD = 16'($urandom);
         end
         cycle("rand");
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
